datapath: RTL and testbench

- 16-bit execution datapath that sits directly downstream of `control_unit`. It holds the eight-entry register file, the operand latches, the ALU and the flag registers.
- It consumes `control_unit`'s register addresses, immediate, ALU select, immediate select and write strobes.
- It returns `zero_flag`/`pos_flag` to `control_unit` for branch decisions.
- It drives a registered `data_out` word on store.

---
 rtl/datapath.sv | 131 +++++++++++++
 tb/tb_datapath.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath
//   16-bit execution datapath driven by control_unit. It holds an eight-entry
//   register file, the operand latches (a_reg/b_reg), a registered ALU result,
//   the zero/positive flags and a registered store word.
//
//   Pipeline, one stage per rising edge:
//     operand  : a_reg <- rf[rs_addr], b_reg <- imm_sel ? imm_data : rf[rt_addr]
//     execute  : result_reg <- ALU(a_reg, b_reg)      (recomputed every edge)
//     writeback: on rf_write, rf[rd_addr] <- result_reg and the flags update
//     store    : on mem_write, data_out <- a_reg
//
//   Strobe semantics: rf_write and mem_write are single-cycle qualifiers with
//   no backpressure. Each acts on the edge where it is sampled high, they are
//   independent of each other, and both may be high on the same edge.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-low clear of all state
//   rf_write   in   write-back strobe
//   rs_addr    in   source A register address
//   rt_addr    in   source B register address
//   rd_addr    in   destination register address
//   imm_data   in   immediate operand
//   imm_sel    in   1: operand B is imm_data, 0: operand B is rf[rt_addr]
//   alu_sel    in   ALU operation select
//   mem_write  in   store strobe (captures a_reg into data_out)
//   zero_flag  out  last written-back result was zero
//   pos_flag   out  last written-back result was strictly positive (signed)
//   data_out   out  registered store word
// -----------------------------------------------------------------------------
module datapath #(
    parameter int WIDTH = 16,
    parameter int REGS  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rf_write,
    input  logic [2:0]       rs_addr,
    input  logic [2:0]       rt_addr,
    input  logic [2:0]       rd_addr,
    input  logic [WIDTH-1:0] imm_data,
    input  logic             imm_sel,
    input  logic [3:0]       alu_sel,
    input  logic             mem_write,
    output logic             zero_flag,
    output logic             pos_flag,
    output logic [WIDTH-1:0] data_out
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_NOT  = 4'b0101,
        ALU_SHL  = 4'b0110,
        ALU_SHR  = 4'b0111,
        ALU_INC  = 4'b1000,
        ALU_DEC  = 4'b1001,
        ALU_MOV  = 4'b1010,
        ALU_MOVI = 4'b1011
    } alu_op_e;

    logic [WIDTH-1:0] rf [REGS];
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] alu_result;

    // ALU: all arithmetic wraps modulo 2^WIDTH; reserved codes yield zero.
    always_comb begin
        alu_result = '0;
        case (alu_sel)
            ALU_ADD:  alu_result = a_reg + b_reg;
            ALU_SUB:  alu_result = a_reg - b_reg;
            ALU_AND:  alu_result = a_reg & b_reg;
            ALU_OR:   alu_result = a_reg | b_reg;
            ALU_XOR:  alu_result = a_reg ^ b_reg;
            ALU_NOT:  alu_result = ~a_reg;
            ALU_SHL:  alu_result = {a_reg[WIDTH-2:0], 1'b0};
            ALU_SHR:  alu_result = {1'b0, a_reg[WIDTH-1:1]};
            ALU_INC:  alu_result = a_reg + WIDTH'(1);
            ALU_DEC:  alu_result = a_reg - WIDTH'(1);
            ALU_MOV:  alu_result = a_reg;
            ALU_MOVI: alu_result = b_reg;
            default:  alu_result = '0;
        endcase
    end

    // Operand reads use the register file contents before this edge's
    // write-back, so there is deliberately no bypass from result_reg.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
        end else begin
            a_reg      <= rf[rs_addr];
            b_reg      <= imm_sel ? imm_data : rf[rt_addr];
            result_reg <= alu_result;
        end
    end

    // Write-back: register file and flags move together; flags hold otherwise.
    // R0 is an ordinary register (no hardwired zero).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REGS; i++) begin
                rf[i] <= '0;
            end
            zero_flag <= 1'b0;
            pos_flag  <= 1'b0;
        end else if (rf_write) begin
            rf[rd_addr] <= result_reg;
            zero_flag   <= (result_reg == '0);
            pos_flag    <= !result_reg[WIDTH-1] && (result_reg != '0);
        end
    end

    // Store register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
        end else if (mem_write) begin
            data_out <= a_reg;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// -----------------------------------------------------------------------------
// tb_datapath
//   Directed, table-driven bench for datapath. Each table row is one four-edge
//   instruction (operand, decode, execute, write-back) followed by a readback
//   of the destination register through the store path (rs -> a_reg ->
//   data_out). Hand-written sequences cover flag hold, store, same-edge
//   read/write, simultaneous strobes and asynchronous reset mid-instruction.
// -----------------------------------------------------------------------------
module tb_datapath;

    logic        clock;
    logic        reset;
    logic        rf_write;
    logic [2:0]  rs_addr;
    logic [2:0]  rt_addr;
    logic [2:0]  rd_addr;
    logic [15:0] imm_data;
    logic        imm_sel;
    logic [3:0]  alu_sel;
    logic        mem_write;
    logic        zero_flag;
    logic        pos_flag;
    logic [15:0] data_out;

    int tests_run;
    int tests_failed;

    datapath #(.WIDTH(16), .REGS(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .rf_write  (rf_write),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rd_addr   (rd_addr),
        .imm_data  (imm_data),
        .imm_sel   (imm_sel),
        .alu_sel   (alu_sel),
        .mem_write (mem_write),
        .zero_flag (zero_flag),
        .pos_flag  (pos_flag),
        .data_out  (data_out)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  alu;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic        isel;
        logic [15:0] imm;
        logic [15:0] exp_val;
        logic        exp_z;
        logic        exp_p;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    // ---------------- helpers ----------------
    // One edge, then settle 1 time unit so outputs are sampled away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Four-edge instruction; rf_write is high only on the fourth edge.
    task automatic exec(input logic [3:0] alu, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input logic isel, input logic [15:0] imm);
        alu_sel  = alu;
        rs_addr  = rs;
        rt_addr  = rt;
        rd_addr  = rd;
        imm_sel  = isel;
        imm_data = imm;
        rf_write = 1'b0;
        tick();            // operands latch
        tick();            // decode
        tick();            // execute: result latches
        rf_write = 1'b1;
        tick();            // write-back
        rf_write = 1'b0;
    endtask

    // Register readback through the store path: a_reg then data_out.
    task automatic read_reg(input logic [2:0] r, output logic [15:0] val);
        rs_addr   = r;
        mem_write = 1'b1;
        tick();
        tick();
        mem_write = 1'b0;
        val = data_out;
    endtask

    logic [15:0] rd_val;

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        //          alu      rs    rt    rd    isel  imm       exp       z     p
        vecs[0]  = '{4'b1011, 3'd0, 3'd0, 3'd7, 1'b1, 16'h0008, 16'h0008, 1'b0, 1'b1}; // MOVI R7,#8
        vecs[1]  = '{4'b1011, 3'd0, 3'd0, 3'd1, 1'b1, 16'h0005, 16'h0005, 1'b0, 1'b1}; // MOVI R1,#5
        vecs[2]  = '{4'b1011, 3'd0, 3'd0, 3'd2, 1'b1, 16'h0003, 16'h0003, 1'b0, 1'b1}; // MOVI R2,#3
        vecs[3]  = '{4'b0000, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000, 16'h0008, 1'b0, 1'b1}; // ADD 5+3
        vecs[4]  = '{4'b0001, 3'd1, 3'd1, 3'd4, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0}; // SUB 5-5
        vecs[5]  = '{4'b0001, 3'd2, 3'd1, 3'd5, 1'b0, 16'h0000, 16'hFFFE, 1'b0, 1'b0}; // SUB 3-5
        vecs[6]  = '{4'b0010, 3'd1, 3'd2, 3'd6, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1}; // AND
        vecs[7]  = '{4'b0011, 3'd1, 3'd2, 3'd6, 1'b0, 16'h0000, 16'h0007, 1'b0, 1'b1}; // OR
        vecs[8]  = '{4'b0100, 3'd1, 3'd2, 3'd6, 1'b0, 16'h0000, 16'h0006, 1'b0, 1'b1}; // XOR
        vecs[9]  = '{4'b0101, 3'd1, 3'd0, 3'd6, 1'b0, 16'h0000, 16'hFFFA, 1'b0, 1'b0}; // NOT 5
        vecs[10] = '{4'b0110, 3'd7, 3'd0, 3'd6, 1'b0, 16'h0000, 16'h0010, 1'b0, 1'b1}; // SHL 8
        vecs[11] = '{4'b0111, 3'd1, 3'd0, 3'd6, 1'b0, 16'h0000, 16'h0002, 1'b0, 1'b1}; // SHR 5
        vecs[12] = '{4'b1000, 3'd1, 3'd0, 3'd6, 1'b0, 16'h0000, 16'h0006, 1'b0, 1'b1}; // INC 5
        vecs[13] = '{4'b1001, 3'd2, 3'd0, 3'd6, 1'b0, 16'h0000, 16'h0002, 1'b0, 1'b1}; // DEC 3
        vecs[14] = '{4'b1010, 3'd3, 3'd0, 3'd6, 1'b0, 16'h0000, 16'h0008, 1'b0, 1'b1}; // MOV R3
        vecs[15] = '{4'b0000, 3'd7, 3'd0, 3'd6, 1'b1, 16'hFFFF, 16'h0007, 1'b0, 1'b1}; // ADD 8+imm wraps
        vecs[16] = '{4'b1011, 3'd0, 3'd0, 3'd0, 1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0}; // MOVI R0,#8000
        vecs[17] = '{4'b0111, 3'd0, 3'd0, 3'd6, 1'b0, 16'h0000, 16'h4000, 1'b0, 1'b1}; // SHR logical
        vecs[18] = '{4'b0110, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0}; // SHL 8000 -> 0
        vecs[19] = '{4'b1011, 3'd0, 3'd0, 3'd0, 1'b1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1}; // max positive
        vecs[20] = '{4'b1011, 3'd0, 3'd0, 3'd6, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0}; // MOVI R6,#FFFF
        vecs[21] = '{4'b1000, 3'd6, 3'd0, 3'd6, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0}; // INC FFFF
        vecs[22] = '{4'b1110, 3'd1, 3'd2, 3'd5, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0}; // reserved
        vecs[23] = '{4'b1010, 3'd1, 3'd0, 3'd5, 1'b0, 16'h0000, 16'h0005, 1'b0, 1'b1}; // MOV R1

        // ---------------- reset ----------------
        reset     = 1'b0;
        rf_write  = 1'b0;
        mem_write = 1'b0;
        rs_addr   = 3'd0;
        rt_addr   = 3'd0;
        rd_addr   = 3'd0;
        imm_data  = 16'h0;
        imm_sel   = 1'b0;
        alu_sel   = 4'b0;
        tick();
        tick();
        check("reset_zero_flag", {15'b0, zero_flag}, 16'h0);
        check("reset_pos_flag",  {15'b0, pos_flag},  16'h0);
        check("reset_data_out",  data_out,           16'h0);
        reset = 1'b1;
        tick();

        // ---------------- table ----------------
        for (int i = 0; i < NVEC; i++) begin
            exec(vecs[i].alu, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].isel, vecs[i].imm);
            check($sformatf("vec%0d_zero_flag", i), {15'b0, zero_flag}, {15'b0, vecs[i].exp_z});
            check($sformatf("vec%0d_pos_flag", i),  {15'b0, pos_flag},  {15'b0, vecs[i].exp_p});
            read_reg(vecs[i].rd, rd_val);
            check($sformatf("vec%0d_rd_value", i), rd_val, vecs[i].exp_val);
        end

        // ---------------- flag hold with rf_write low ----------------
        // Last row left zero=0, pos=1; an alu_sel that would produce zero
        // must not disturb the flags without a write-back strobe.
        rs_addr = 3'd1;
        rt_addr = 3'd1;
        imm_sel = 1'b0;
        alu_sel = 4'b0001;
        tick();
        alu_sel = 4'b1110;
        tick();
        alu_sel = 4'b0101;
        tick();
        check("hold_zero_flag", {15'b0, zero_flag}, 16'h0);
        check("hold_pos_flag",  {15'b0, pos_flag},  16'h1);

        // ---------------- store and hold ----------------
        read_reg(3'd3, rd_val);
        check("store_r3", rd_val, 16'h0008);
        rs_addr = 3'd1;
        tick();
        tick();
        check("store_hold", data_out, 16'h0008);

        // ---------------- same-edge read/write of R4 ----------------
        alu_sel  = 4'b1011;
        imm_sel  = 1'b1;
        imm_data = 16'h1234;
        rd_addr  = 3'd4;
        rs_addr  = 3'd4;
        tick();
        tick();
        tick();
        rf_write = 1'b1;
        tick();                    // R4 written; a_reg samples old R4
        rf_write  = 1'b0;
        mem_write = 1'b1;
        tick();                    // data_out <- a_reg from write-back edge
        check("same_edge_old", data_out, 16'h0000);
        tick();                    // data_out <- a_reg from the edge after
        check("same_edge_new", data_out, 16'h1234);
        mem_write = 1'b0;

        // ---------------- simultaneous strobes ----------------
        alu_sel  = 4'b1011;
        imm_sel  = 1'b1;
        imm_data = 16'h00AA;
        rd_addr  = 3'd5;
        rs_addr  = 3'd1;
        tick();
        tick();
        tick();
        rf_write  = 1'b1;
        mem_write = 1'b1;
        tick();
        rf_write  = 1'b0;
        mem_write = 1'b0;
        check("both_data_out", data_out, 16'h0005);
        check("both_pos_flag", {15'b0, pos_flag}, 16'h1);
        read_reg(3'd5, rd_val);
        check("both_r5", rd_val, 16'h00AA);

        // ---------------- reset between execute and write-back ----------------
        alu_sel  = 4'b1011;
        imm_sel  = 1'b1;
        imm_data = 16'h0055;
        rd_addr  = 3'd2;
        tick();
        tick();
        tick();
        rf_write = 1'b1;
        reset    = 1'b0;
        #1;
        check("async_zero_flag", {15'b0, zero_flag}, 16'h0);
        check("async_pos_flag",  {15'b0, pos_flag},  16'h0);
        check("async_data_out",  data_out,           16'h0);
        tick();
        tick();
        rf_write = 1'b0;
        reset    = 1'b1;
        read_reg(3'd2, rd_val);
        check("reset_r2_not_written", rd_val, 16'h0000);
        read_reg(3'd7, rd_val);
        check("reset_r7_cleared", rd_val, 16'h0000);
        check("reset_flags_after", {14'b0, zero_flag, pos_flag}, 16'h0);

        // ---------------- function after reset ----------------
        exec(4'b1011, 3'd0, 3'd0, 3'd1, 1'b1, 16'h0003);
        check("post_reset_pos_flag", {15'b0, pos_flag}, 16'h1);
        read_reg(3'd1, rd_val);
        check("post_reset_r1", rd_val, 16'h0003);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
